// File: rtl/aes_key_expander_seq.sv
`default_nettype none
// ============================================================================
// aes_key_expander_seq : iterative AES key schedule, one 32-bit word per clock,
// random-access round-key read port. AES_KEYEXP_LONG_EN adds 192/256-bit keys.
// Revision 1.0
// ============================================================================

module aes_keyexp_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s_o = SBOX[a_i];

endmodule

module aes_key_expander_seq #(
  parameter int MAX_WORDS = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  output logic         done,
  output logic         keys_valid,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

`ifdef AES_KEYEXP_LONG_EN
  localparam int DEPTH      = MAX_WORDS;
  localparam int LOAD_WORDS = 8;
`else
  localparam int DEPTH      = (MAX_WORDS < 44) ? MAX_WORDS : 44;
  localparam int LOAD_WORDS = 4;
`endif
  localparam int AW = $clog2(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [2:0]    phase_q, phase_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [3:0]    nr_q, nr_d;
  logic          done_q, done_d;
  logic          kv_q, kv_d;
  logic [31:0]   store_q [DEPTH];

  logic          accept;
  logic          expand_en;
  logic          rot_phase;
  logic          mid_phase;
  logic          phase_wrap;
  logic [3:0]    nk;
  logic [3:0]    sel_nk;
  logic [3:0]    sel_nr;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] idx_prev;
  logic [AW-1:0] idx_old;
  logic [31:0]   prev_word;
  logic [31:0]   sub_in;
  logic [31:0]   sub_out;
  logic [31:0]   temp_word;
  logic [31:0]   new_word;
  logic [7:0]    rcon_next;
  logic [31:0]   key_w [8];

`ifdef AES_KEYEXP_LONG_EN
  logic [3:0]    nk_q, nk_d;
  logic [AW-1:0] last_q, last_d;

  always_comb begin
    sel_nk = 4'd4;
    sel_nr = 4'd10;
    case (key_len)
      2'b01:   begin sel_nk = 4'd6; sel_nr = 4'd12; end
      2'b10:   begin sel_nk = 4'd8; sel_nr = 4'd14; end
      default: begin sel_nk = 4'd4; sel_nr = 4'd10; end
    endcase
  end

  always_comb begin
    nk_d   = nk_q;
    last_d = last_q;
    if (accept) begin
      nk_d   = sel_nk;
      // 4*(Nr+1)-1 is just Nr with two ones appended
      last_d = AW'({sel_nr, 2'b11});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nk_q   <= 4'd4;
      last_q <= AW'(43);
    end else begin
      nk_q   <= nk_d;
      last_q <= last_d;
    end
  end

  assign nk        = nk_q;
  assign last_idx  = last_q;
  assign mid_phase = (nk_q == 4'd8) && (phase_q == 3'd4);
`else
  logic unused_cfg;

  assign sel_nk     = 4'd4;
  assign sel_nr     = 4'd10;
  assign nk         = 4'd4;
  assign last_idx   = AW'(43);
  assign mid_phase  = 1'b0;
  assign unused_cfg = ^{key_len, key_in[127:0]};
`endif

  for (genvar g = 0; g < 8; g++) begin : g_key_words
    assign key_w[g] = key_in[255-32*g -: 32];
  end

  assign key_ready  = (state_q != S_EXPAND);
  assign accept     = rst_n & key_valid & key_ready;
  assign expand_en  = rst_n & (state_q == S_EXPAND);
  assign rot_phase  = (phase_q == 3'd0);
  assign phase_wrap = ({1'b0, phase_q} == (nk - 4'd1));

  assign idx_prev  = wcnt_q - AW'(1);
  assign idx_old   = wcnt_q - AW'(nk);
  assign prev_word = store_q[idx_prev];
  assign sub_in    = rot_phase ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  // Shared by the RotWord/Rcon step and the Nk=8 mid-block SubWord step
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_keyexp_sbox u_sbox (
      .a_i (sub_in[8*g +: 8]),
      .s_o (sub_out[8*g +: 8])
    );
  end

  assign temp_word = rot_phase ? (sub_out ^ {rcon_q, 24'h0}) :
                     mid_phase ? sub_out : prev_word;
  assign new_word  = store_q[idx_old] ^ temp_word;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    nr_d    = nr_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    if (accept) begin
      state_d = S_EXPAND;
      wcnt_d  = AW'(sel_nk);
      phase_d = 3'd0;
      rcon_d  = 8'h01;
      nr_d    = sel_nr;
      kv_d    = 1'b0;
    end else if (state_q == S_EXPAND) begin
      wcnt_d  = wcnt_q + AW'(1);
      phase_d = phase_wrap ? 3'd0 : (phase_q + 3'd1);
      if (rot_phase) begin
        rcon_d = rcon_next;
      end
      if (wcnt_q == last_idx) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        kv_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      phase_q <= 3'd0;
      rcon_q  <= 8'h01;
      nr_q    <= 4'd0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
      nr_q    <= nr_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
    end
  end

  // Store is deliberately not reset; the keys_valid gate on rk_out hides stale words
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < LOAD_WORDS; k++) begin
        if (4'(k) < sel_nk) begin
          store_q[AW'(k)] <= key_w[k[2:0]];
        end
      end
    end else if (expand_en) begin
      store_q[wcnt_q] <= new_word;
    end
  end

  logic [AW-1:0] rk_base;
  logic [31:0]   rk_word [4];
  logic          rk_hit;

  assign rk_base = AW'({rk_idx, 2'b00});
  assign rk_hit  = kv_q && (rk_idx <= nr_q);

  for (genvar g = 0; g < 4; g++) begin : g_rk_read
    assign rk_word[g] = store_q[rk_base + AW'(g)];
  end

  assign rk_out     = rk_hit ? {rk_word[0], rk_word[1], rk_word[2], rk_word[3]} : 128'd0;
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign num_rounds = nr_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander_seq.sv
`default_nettype none
// Randomized scoreboard bench for aes_key_expander_seq against an arithmetic
// FIPS-197 key-schedule model (S-box derived from GF(2^8) inversion).
`timescale 1ns/1ps

module tb_aes_key_expander_seq;

`ifdef AES_KEYEXP_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         done;
  logic         keys_valid;
  logic [3:0]   num_rounds;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  aes_key_expander_seq #(.MAX_WORDS(60)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .key_len    (key_len),
    .done       (done),
    .keys_valid (keys_valid),
    .num_rounds (num_rounds),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1919:0] rks;
    logic [3:0]    nr;
    logic [31:0]   lat;
    logic [31:0]   acc;
    logic          gen;
    logic [3:0]    gidx;
    logic [127:0]  gval;
  } exp_t;

  exp_t q[$];
  exp_t mon_cur;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] msbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [15:0] d;
    d = {x, x} << k;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      msbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    logic [31:0] s;
    for (int b = 0; b < 4; b++) s[8*b +: 8] = msbox[w[8*b +: 8]];
    return s;
  endfunction

  function automatic exp_t model(input logic [255:0] key, input logic [1:0] len);
    exp_t e;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr, total;
    nk = 4;
    if (LONG_EN && len == 2'b01) nk = 6;
    if (LONG_EN && len == 2'b10) nk = 8;
    nr = nk + 6;
    total = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    e = '0;
    for (int r = 0; r <= nr; r++) e.rks[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    e.nr  = 4'(nr);
    e.lat = 32'(total - nk);
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected: done=1 required 0 (no key pending)");
        end else begin
          mon_cur = q.pop_front();
          chk("latency", 128'(cyc - mon_cur.acc), 128'(mon_cur.lat));
          chk("num_rounds", 128'(num_rounds), 128'(mon_cur.nr));
          chk("keys_valid_at_done", 128'(keys_valid), 128'(1));
          for (int r = 0; r < 16; r++) begin
            rk_idx = 4'(r);
            #1;
            chk($sformatf("rk_out[%0d]", r), rk_out,
                (r <= int'(mon_cur.nr)) ? mon_cur.rks[r*128 +: 128] : 128'd0);
            if (mon_cur.gen && 4'(r) == mon_cur.gidx)
              chk($sformatf("rk_fips[%0d]", r), rk_out, mon_cur.gval);
          end
          rk_idx = 4'($urandom);
        end
      end else if (q.size() != 0 && cyc >= q[0].acc) begin
        chk("keys_valid_low_expand", 128'(keys_valid), 128'(0));
        chk("rk_out_gated_expand", rk_out, 128'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_key(input logic [255:0] k, input logic [1:0] l, input bit g,
                          input logic [3:0] gi, input logic [127:0] gv);
    exp_t e;
    int n;
    key_in = k; key_len = l; key_valid = 1'b1;
    n = 0;
    while (key_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (key_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL accept_timeout: key_ready=%b required 1", key_ready);
      key_valid = 1'b0;
      return;
    end
    e = model(k, l);
    e.acc = cyc + 1;
    e.gen = g; e.gidx = gi; e.gval = gv;
    q.push_back(e);
    @(negedge clk);
    key_valid = 1'b0;
    key_in = {8{$urandom}};
    key_len = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: %0d expansions pending, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_keys_valid"}, 128'(keys_valid), 128'(0));
    chk({tag, "_num_rounds"}, 128'(num_rounds), 128'(0));
    chk({tag, "_rk_out"}, rk_out, 128'd0);
  endtask

  localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] A2_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] A3_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A2_RK12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  initial begin
    logic [255:0] a1_full;
    logic [255:0] a2_full;
    logic [255:0] rk;
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; key_len = 2'b00; rk_idx = 4'd0;
    build_sbox();
    a1_full = {A1_KEY, {4{$urandom}}};
    a2_full = {A2_KEY, {2{$urandom}}};
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // A.1, with a competing key held through EXPAND (must be ignored)
    load_key(a1_full, 2'b00, 1'b1, 4'd10, A1_RK10);
    key_valid = 1'b1; key_in = {8{$urandom}}; key_len = 2'b10;
    for (int n = 0; n < 20; n++) begin
      chk("key_ready_low_expand", 128'(key_ready), 128'(0));
      @(negedge clk);
    end
    key_valid = 1'b0;
    wait_idle();

    load_key(a2_full, 2'b01, LONG_EN, 4'd12, A2_RK12);
    wait_idle();
    load_key(A3_KEY, 2'b10, LONG_EN, 4'd14, A3_RK14);
    wait_idle();
    load_key(a1_full, 2'b11, 1'b1, 4'd10, A1_RK10);
    wait_idle();

    // Abort mid-expansion, then reload A.1
    load_key(A3_KEY, 2'b10, 1'b0, 4'd0, 128'd0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("abort");
    load_key(a1_full, 2'b00, 1'b1, 4'd10, A1_RK10);
    wait_idle();

    // Back-to-back: A.3 accepted in the done cycle of A.1
    load_key(a1_full, 2'b00, 1'b1, 4'd10, A1_RK10);
    load_key(A3_KEY, 2'b10, LONG_EN, 4'd14, A3_RK14);
    wait_idle();

    for (int n = 0; n < 12; n++) begin
      rk = {8{$urandom}};
      load_key(rk, 2'($urandom_range(0, 3)), 1'b0, 4'd0, 128'd0);
      if ($urandom_range(0, 1) == 1) wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
